// File: rtl/dcache_flush_engine.sv
// dcache_flush_engine
// Walks every line of the direct-mapped data cache on request. Each valid and
// dirty line is written back to Data_Memory over the enable/write/ack port, and
// then its dirty bit is cleared. busy_o stalls the pipeline for the whole walk.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for flush_i; index and write-back count armed on start
//   S_READ  | present idx to the tag/data SRAMs (one-cycle read latency)
//   S_CHECK | SRAM outputs valid; capture tag/data, decide write-back or skip
//   S_WB    | memory write held stable until mem_ack_i
//   S_CLEAR | one-cycle dirty-bit clear strobe for idx
//   S_NEXT  | advance idx, or finish after the last line
//   S_DONE  | one-cycle done_o pulse, then back to idle
module dcache_flush_engine #(
  parameter int NUM_LINES = 32,
  parameter int INDEX_W   = 5,
  parameter int TAG_W     = 22,
  parameter int OFFSET_W  = 5,
  parameter int LINE_W    = 256,
  parameter int ADDR_W    = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [INDEX_W-1:0]  sram_idx_o,
  input  logic                sram_valid_i,
  input  logic                sram_dirty_i,
  input  logic [TAG_W-1:0]    sram_tag_i,
  input  logic [LINE_W-1:0]   sram_data_i,
  output logic                clr_dirty_o,
  output logic                mem_enable_o,
  output logic                mem_write_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [LINE_W-1:0]   mem_data_o,
  input  logic                mem_ack_i,
  output logic [INDEX_W:0]    wb_count_o
);

  localparam int FULL_W = TAG_W + INDEX_W + OFFSET_W;
  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(NUM_LINES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CHECK,
    S_WB,
    S_CLEAR,
    S_NEXT,
    S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [INDEX_W-1:0]  idx;
  logic [INDEX_W:0]    wb_count;
  logic [TAG_W-1:0]    tag_q;
  logic [LINE_W-1:0]   data_q;
  logic [FULL_W-1:0]   addr_full;

  // State register; reset aborts any scan immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and per-state outputs.
  always_comb begin
    state_nxt    = state;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    sram_idx_o   = idx;
    clr_dirty_o  = 1'b0;
    mem_enable_o = 1'b0;
    case (state)
      S_IDLE: begin
        busy_o     = 1'b0;
        sram_idx_o = '0;
        if (flush_i) state_nxt = S_READ;
      end
      S_READ:  state_nxt = S_CHECK;
      S_CHECK: state_nxt = (sram_valid_i && sram_dirty_i) ? S_WB : S_NEXT;
      S_WB: begin
        mem_enable_o = 1'b1;
        if (mem_ack_i) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        clr_dirty_o = 1'b1;
        state_nxt   = S_NEXT;
      end
      S_NEXT:  state_nxt = (idx == LAST_IDX) ? S_DONE : S_READ;
      S_DONE: begin
        done_o     = 1'b1;
        sram_idx_o = '0;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Scan index, write-back counter and holding registers for the line in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx      <= '0;
      wb_count <= '0;
      tag_q    <= '0;
      data_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (flush_i) begin
            idx      <= '0;
            wb_count <= '0;
          end
        end
        S_CHECK: begin
          tag_q  <= sram_tag_i;
          data_q <= sram_data_i;
        end
        S_WB: begin
          if (mem_ack_i) wb_count <= wb_count + 1'b1;
        end
        S_NEXT: begin
          if (idx != LAST_IDX) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Line address is zero-extended to the memory address width.
  assign addr_full   = {tag_q, idx, {OFFSET_W{1'b0}}};
  assign mem_write_o = mem_enable_o;
  assign mem_addr_o  = mem_enable_o ? ADDR_W'(addr_full) : '0;
  assign mem_data_o  = mem_enable_o ? data_q : '0;
  assign wb_count_o  = wb_count;

endmodule

// File: tb/tb_dcache_flush_engine.sv
// Directed bench for dcache_flush_engine: a 32-line instance with an SRAM and
// memory model, plus a 64-line instance for the wider-index configuration.
module tb_dcache_flush_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 32-line instance
  logic         a_flush = 1'b0;
  logic         a_busy, a_done, a_clr, a_en, a_wr, a_ack;
  logic         a_valid = 1'b0, a_dirty = 1'b0;
  logic [4:0]   a_idx;
  logic [21:0]  a_tag = '0;
  logic [255:0] a_rdata = '0, a_mdata;
  logic [31:0]  a_addr;
  logic [5:0]   a_wbc;

  // 64-line instance
  logic         b_flush = 1'b0;
  logic         b_busy, b_done, b_clr, b_en, b_wr, b_ack;
  logic         b_valid = 1'b0, b_dirty = 1'b0;
  logic [5:0]   b_idx;
  logic [20:0]  b_tag = '0;
  logic [255:0] b_rdata = '0, b_mdata;
  logic [31:0]  b_addr;
  logic [6:0]   b_wbc;
  logic         b_dirty_en = 1'b0;

  dcache_flush_engine u_a (
    .clk_i(clk), .rst_i(rst), .flush_i(a_flush), .busy_o(a_busy), .done_o(a_done),
    .sram_idx_o(a_idx), .sram_valid_i(a_valid), .sram_dirty_i(a_dirty),
    .sram_tag_i(a_tag), .sram_data_i(a_rdata), .clr_dirty_o(a_clr),
    .mem_enable_o(a_en), .mem_write_o(a_wr), .mem_addr_o(a_addr),
    .mem_data_o(a_mdata), .mem_ack_i(a_ack), .wb_count_o(a_wbc)
  );

  dcache_flush_engine #(.NUM_LINES(64), .INDEX_W(6), .TAG_W(21)) u_b (
    .clk_i(clk), .rst_i(rst), .flush_i(b_flush), .busy_o(b_busy), .done_o(b_done),
    .sram_idx_o(b_idx), .sram_valid_i(b_valid), .sram_dirty_i(b_dirty),
    .sram_tag_i(b_tag), .sram_data_i(b_rdata), .clr_dirty_o(b_clr),
    .mem_enable_o(b_en), .mem_write_o(b_wr), .mem_addr_o(b_addr),
    .mem_data_o(b_mdata), .mem_ack_i(b_ack), .wb_count_o(b_wbc)
  );

  // SRAM contents for instance A; a clear is honoured only within the current gen
  logic         m_valid [32];
  logic         m_dirty [32];
  logic [21:0]  m_tag   [32];
  logic [255:0] m_data  [32];
  int           clr_gen [32];
  int           gen = 0;
  int           ack_delay = 0;
  int           a_cyc = 0;

  always @(posedge clk) begin
    a_valid <= m_valid[a_idx];
    a_dirty <= m_dirty[a_idx] && (clr_gen[a_idx] != gen + 1);
    a_tag   <= m_tag[a_idx];
    a_rdata <= m_data[a_idx];
    a_cyc   <= a_en ? a_cyc + 1 : 0;
  end
  assign a_ack = a_en && (a_cyc == ack_delay);

  always @(posedge clk) begin
    b_valid <= (b_idx == 6'd63);
    b_dirty <= b_dirty_en && (b_idx == 6'd63);
    b_tag   <= 21'h1ABCD;
    b_rdata <= 256'hBEEF;
  end
  assign b_ack = b_en;

  // Monitors, sampled on the falling edge
  int           a_busy_tot = 0, a_done_tot = 0, a_wr_tot = 0, a_clr_tot = 0;
  int           a_en_tot = 0, a_unstable = 0, a_wr_neq = 0, a_last_wbcyc = 0;
  logic [31:0]  a_wr_addr [16];
  logic [255:0] a_wr_data [16];
  int           a_clr_idx [16];
  logic [31:0]  a_prev_addr = '0;
  logic [255:0] a_prev_data = '0;

  always @(negedge clk) begin
    if (a_busy) a_busy_tot++;
    if (a_done) a_done_tot++;
    if (a_wr !== a_en) a_wr_neq++;
    if (a_clr) begin
      if (a_clr_tot < 16) a_clr_idx[a_clr_tot] = int'(a_idx);
      clr_gen[a_idx] = gen + 1;
      a_clr_tot++;
    end
    if (a_en) begin
      a_en_tot++;
      if (a_cyc != 0 && (a_addr !== a_prev_addr || a_mdata !== a_prev_data)) a_unstable++;
      a_prev_addr = a_addr;
      a_prev_data = a_mdata;
      if (a_ack) begin
        if (a_wr_tot < 16) begin
          a_wr_addr[a_wr_tot] = a_addr;
          a_wr_data[a_wr_tot] = a_mdata;
        end
        a_last_wbcyc = a_cyc + 1;
        a_wr_tot++;
      end
    end
  end

  int          b_busy_tot = 0, b_wr_tot = 0;
  logic [31:0] b_last_addr = '0;

  always @(negedge clk) begin
    if (b_busy) b_busy_tot++;
    if (b_en && b_ack) begin
      b_last_addr = b_addr;
      b_wr_tot++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_a();
    gen++;
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
      m_data[i]  = '0;
    end
  endtask

  task automatic pulse_a();
    @(negedge clk) a_flush = 1'b1;
    @(negedge clk) a_flush = 1'b0;
  endtask

  task automatic pulse_b();
    @(negedge clk) b_flush = 1'b1;
    @(negedge clk) b_flush = 1'b0;
  endtask

  task automatic wait_a_idle(input int limit);
    int n = 0;
    while (a_busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("a_idle_timeout", (n >= limit), 0);
  endtask

  task automatic wait_b_idle(input int limit);
    int n = 0;
    while (b_busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("b_idle_timeout", (n >= limit), 0);
  endtask

  int bb, db, wb, eb, cb, ub;

  initial begin
    for (int i = 0; i < 32; i++) clr_gen[i] = 0;
    clear_a();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_en", a_en, 0);
    chk("rst_wbc", a_wbc, 0);
    chk("rst_idx", a_idx, 0);
    chk("rst_addr", a_addr, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: empty cache
    bb = a_busy_tot; db = a_done_tot; eb = a_en_tot;
    pulse_a();
    wait_a_idle(300);
    chk("t1_busy_cycles", a_busy_tot - bb, 97);
    chk("t1_done_pulses", a_done_tot - db, 1);
    chk("t1_mem_cycles", a_en_tot - eb, 0);
    chk("t1_wbc", a_wbc, 0);

    // 2: line 3 dirty, ack after 10 wait cycles
    clear_a();
    m_valid[3] = 1'b1; m_dirty[3] = 1'b1; m_tag[3] = 22'h1; m_data[3] = 256'hA5;
    ack_delay = 10;
    wb = a_wr_tot; cb = a_clr_tot; ub = a_unstable;
    pulse_a();
    wait_a_idle(400);
    chk("t2_writes", a_wr_tot - wb, 1);
    chk("t2_addr", a_wr_addr[wb], 32'h0000_0460);
    chk("t2_data", a_wr_data[wb], 256'hA5);
    chk("t2_wb_cycles", a_last_wbcyc, 11);
    chk("t2_unstable", a_unstable - ub, 0);
    chk("t2_clears", a_clr_tot - cb, 1);
    chk("t2_clr_idx", a_clr_idx[cb], 3);
    chk("t2_wbc", a_wbc, 1);

    // 3: lines 0 and 31 dirty, line 5 clean, ack in first WB cycle
    clear_a();
    m_valid[0]  = 1'b1; m_dirty[0]  = 1'b1; m_tag[0]  = 22'h2;      m_data[0]  = 256'h1111;
    m_valid[31] = 1'b1; m_dirty[31] = 1'b1; m_tag[31] = 22'h3FFFFF; m_data[31] = 256'h3131;
    m_valid[5]  = 1'b1; m_dirty[5]  = 1'b0; m_tag[5]  = 22'h7;      m_data[5]  = 256'h5555;
    ack_delay = 0;
    wb = a_wr_tot; cb = a_clr_tot;
    pulse_a();
    wait_a_idle(400);
    chk("t3_writes", a_wr_tot - wb, 2);
    chk("t3_addr0", a_wr_addr[wb], 32'h0000_0800);
    chk("t3_data0", a_wr_data[wb], 256'h1111);
    chk("t3_addr31", a_wr_addr[wb + 1], 32'hFFFF_FFE0);
    chk("t3_data31", a_wr_data[wb + 1], 256'h3131);
    chk("t3_clears", a_clr_tot - cb, 2);
    chk("t3_clr_first", a_clr_idx[cb], 0);
    chk("t3_clr_second", a_clr_idx[cb + 1], 31);
    chk("t3_wbc", a_wbc, 2);

    // 4: reset during a stalled write-back, then rescan
    clear_a();
    m_valid[3] = 1'b1; m_dirty[3] = 1'b1; m_tag[3] = 22'h1; m_data[3] = 256'hA5;
    ack_delay = 1000;
    wb = a_wr_tot;
    pulse_a();
    begin
      int n = 0;
      while (!a_en && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("t4_wb_timeout", (n >= 100), 0);
    end
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t4_rst_en", a_en, 0);
    chk("t4_rst_busy", a_busy, 0);
    chk("t4_rst_addr", a_addr, 0);
    chk("t4_rst_wbc", a_wbc, 0);
    @(negedge clk) rst = 1'b0;
    chk("t4_no_write", a_wr_tot - wb, 0);
    ack_delay = 2;
    pulse_a();
    wait_a_idle(400);
    chk("t4_rewrite", a_wr_tot - wb, 1);
    chk("t4_addr", a_wr_addr[wb], 32'h0000_0460);
    chk("t4_wb_cycles", a_last_wbcyc, 3);
    chk("t4_wbc", a_wbc, 1);

    // 5: flush_i repeated while busy and in DONE
    clear_a();
    m_valid[3] = 1'b1; m_dirty[3] = 1'b1; m_tag[3] = 22'h1; m_data[3] = 256'hA5;
    ack_delay = 3;
    wb = a_wr_tot; db = a_done_tot;
    pulse_a();
    repeat (5) @(negedge clk);
    a_flush = 1'b1;
    @(negedge clk) a_flush = 1'b0;
    begin
      int n = 0;
      while (!a_done && n < 300) begin
        @(negedge clk);
        n++;
      end
      chk("t5_done_timeout", (n >= 300), 0);
    end
    a_flush = 1'b1;
    @(negedge clk) a_flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_no_restart", a_busy, 0);
    chk("t5_done_pulses", a_done_tot - db, 1);
    chk("t5_writes", a_wr_tot - wb, 1);
    chk("t5_wbc", a_wbc, 1);
    wb = a_wr_tot;
    pulse_a();
    wait_a_idle(300);
    chk("t5_second_writes", a_wr_tot - wb, 0);
    chk("t5_second_wbc", a_wbc, 0);

    // 6: 64-line configuration
    b_dirty_en = 1'b1;
    wb = b_wr_tot;
    pulse_b();
    wait_b_idle(600);
    chk("t6_writes", b_wr_tot - wb, 1);
    chk("t6_addr63", b_last_addr, 32'h0D5E_6FE0);
    chk("t6_wbc", b_wbc, 1);
    b_dirty_en = 1'b0;
    bb = b_busy_tot; wb = b_wr_tot;
    pulse_b();
    wait_b_idle(600);
    chk("t6_clean_busy", b_busy_tot - bb, 193);
    chk("t6_clean_writes", b_wr_tot - wb, 0);
    chk("t6_clean_wbc", b_wbc, 0);

    chk("write_eq_enable", a_wr_neq, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
